// File: rtl/scope_pkg.sv
// Shared definitions for the scope trigger/capture block: FSM states,
// sample field position inside the XADC word and edge polarity codes.
package scope_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      ARMED = 3'd2,
      POST  = 3'd3,
      DONE  = 3'd4
   } state_t;

   // 12-bit conversion result sits left-justified in the 16-bit XADC word
   localparam int SAMPLE_MSB = 15;
   localparam int SAMPLE_LSB = 4;

   localparam logic EDGE_RISE = 1'b0;
   localparam logic EDGE_FALL = 1'b1;

endpackage

// File: rtl/scope_sample_ram.sv
// Simple dual-port sample buffer: one synchronous write port, one
// synchronous registered read port. The array itself is never reset so it
// maps onto block RAM; only the read output register is reset.
module scope_sample_ram #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 12
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // registered read; output holds when no read is issued
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/scope_trigger_capture.sv
// Oscilloscope-style edge trigger and circular capture buffer fed by the
// XADC reader. Keeps pretrig samples before the trigger and fills the rest
// of the buffer after it, then exposes a trigger-aligned read port.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no capture in progress, samples ignored
//   FILL  | collecting the first pretrig samples, trigger not evaluated
//   ARMED | writing continuously, waiting for the edge condition
//   POST  | trigger seen, writing the remaining post-trigger samples
//   DONE  | buffer frozen, reads allowed
module scope_trigger_capture
   import scope_pkg::*;
#(
   parameter int ADDR_W   = 10,
   parameter int SAMPLE_W = 12
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [15:0]         val_i,
   input  logic                eoc_i,
   input  logic                arm_i,
   input  logic                abort_i,
   input  logic [SAMPLE_W-1:0] trig_level_i,
   input  logic                trig_edge_i,
   input  logic [ADDR_W-1:0]   pretrig_i,
   input  logic                rd_en_i,
   input  logic [ADDR_W-1:0]   rd_addr_i,
   output logic [SAMPLE_W-1:0] rd_data_o,
   output logic                rd_valid_o,
   output logic                done_o,
   output logic [2:0]          state_o,
   output logic [ADDR_W-1:0]   trig_addr_o
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   state_t state;
   state_t state_nx;

   logic [ADDR_W-1:0]   wr_ptr;
   logic [ADDR_W-1:0]   fill_cnt;
   logic [ADDR_W-1:0]   post_cnt;
   logic [ADDR_W-1:0]   pretrig_q;
   logic [ADDR_W-1:0]   trig_addr;
   logic [ADDR_W-1:0]   post_load;
   logic [ADDR_W-1:0]   rd_phys;
   logic [SAMPLE_W-1:0] level_q;
   logic [SAMPLE_W-1:0] prev;
   logic [SAMPLE_W-1:0] sample;
   logic                edge_sel_q;
   logic                prev_valid;
   logic                rd_valid;
   logic                done;
   logic                do_arm;
   logic                do_write;
   logic                do_trig;
   logic                trig_hit;
   logic                rd_issue;
   logic                unused_low;

   assign sample     = val_i[SAMPLE_MSB:SAMPLE_LSB];
   assign unused_low = ^val_i[SAMPLE_LSB-1:0];

   // post-trigger samples still to take after the trigger sample itself
   assign post_load = LAST - pretrig_q;

   // logical index 0 is the oldest pre-trigger sample
   assign rd_phys  = trig_addr - pretrig_q + rd_addr_i;
   assign rd_issue = rd_en_i && (state == DONE);

   assign rd_valid_o  = rd_valid;
   assign done_o      = done;
   assign state_o     = state;
   assign trig_addr_o = trig_addr;

   // edge detector against the latched level, unsigned compare
   always_comb begin
      trig_hit = 1'b0;
      if (prev_valid) begin
         if (edge_sel_q == EDGE_FALL) begin
            trig_hit = (prev > level_q) && (sample <= level_q);
         end else begin
            trig_hit = (prev < level_q) && (sample >= level_q);
         end
      end
   end

   // state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // next-state and datapath strobes; abort overrides everything
   always_comb begin
      state_nx = state;
      do_arm   = 1'b0;
      do_write = 1'b0;
      do_trig  = 1'b0;
      if (abort_i) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (arm_i) begin
                  do_arm   = 1'b1;
                  state_nx = (pretrig_i == '0) ? ARMED : FILL;
               end
            end
            FILL: begin
               if (eoc_i) begin
                  do_write = 1'b1;
                  if ((fill_cnt + ONE) == pretrig_q) begin
                     state_nx = ARMED;
                  end
               end
            end
            ARMED: begin
               if (eoc_i) begin
                  do_write = 1'b1;
                  if (trig_hit) begin
                     do_trig  = 1'b1;
                     state_nx = (post_load == '0) ? DONE : POST;
                  end
               end
            end
            POST: begin
               if (eoc_i) begin
                  do_write = 1'b1;
                  if (post_cnt == ONE) begin
                     state_nx = DONE;
                  end
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // capture datapath: config latch, write pointer, counters, trigger address
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr     <= '0;
         fill_cnt   <= '0;
         post_cnt   <= '0;
         pretrig_q  <= '0;
         trig_addr  <= '0;
         level_q    <= '0;
         edge_sel_q <= EDGE_RISE;
         prev       <= '0;
         prev_valid <= 1'b0;
         done       <= 1'b0;
         rd_valid   <= 1'b0;
      end else begin
         done     <= (state_nx == DONE);
         rd_valid <= rd_issue;
         if (do_arm) begin
            // pretrig_i is ADDR_W wide, so it can never exceed DEPTH-1
            level_q    <= trig_level_i;
            edge_sel_q <= trig_edge_i;
            pretrig_q  <= pretrig_i;
            prev_valid <= 1'b0;
            fill_cnt   <= '0;
         end
         if (do_write) begin
            wr_ptr     <= wr_ptr + ONE;
            prev       <= sample;
            prev_valid <= 1'b1;
            if (state == FILL) begin
               fill_cnt <= fill_cnt + ONE;
            end
            if (state == POST) begin
               post_cnt <= post_cnt - ONE;
            end
         end
         if (do_trig) begin
            trig_addr <= wr_ptr;
            post_cnt  <= post_load;
         end
      end
   end

   scope_sample_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (SAMPLE_W)
   ) u_ram (
      .clk   (clk),
      .rstn  (rstn),
      .we    (do_write),
      .waddr (wr_ptr),
      .wdata (sample),
      .re    (rd_issue),
      .raddr (rd_phys),
      .rdata (rd_data_o)
   );

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Directed bench for scope_trigger_capture with a 16-entry buffer.
module tb_scope_trigger_capture;

   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [15:0]   val_i = '0;
   logic          eoc_i = 1'b0;
   logic          arm_i = 1'b0;
   logic          abort_i = 1'b0;
   logic [11:0]   trig_level_i = '0;
   logic          trig_edge_i = 1'b0;
   logic [AW-1:0] pretrig_i = '0;
   logic          rd_en_i = 1'b0;
   logic [AW-1:0] rd_addr_i = '0;
   logic [11:0]   rd_data_o;
   logic          rd_valid_o;
   logic          done_o;
   logic [2:0]    state_o;
   logic [AW-1:0] trig_addr_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   scope_trigger_capture #(.ADDR_W(AW), .SAMPLE_W(12)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .val_i        (val_i),
      .eoc_i        (eoc_i),
      .arm_i        (arm_i),
      .abort_i      (abort_i),
      .trig_level_i (trig_level_i),
      .trig_edge_i  (trig_edge_i),
      .pretrig_i    (pretrig_i),
      .rd_en_i      (rd_en_i),
      .rd_addr_i    (rd_addr_i),
      .rd_data_o    (rd_data_o),
      .rd_valid_o   (rd_valid_o),
      .done_o       (done_o),
      .state_o      (state_o),
      .trig_addr_o  (trig_addr_o)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic arm(input logic [AW-1:0] pt, input logic [11:0] lvl, input logic edg);
      @(negedge clk);
      arm_i        = 1'b1;
      pretrig_i    = pt;
      trig_level_i = lvl;
      trig_edge_i  = edg;
      @(negedge clk);
      arm_i = 1'b0;
   endtask

   // one conversion every 4 clocks; low nibble is junk the DUT must drop
   task automatic send(input logic [11:0] s);
      @(negedge clk);
      eoc_i = 1'b1;
      val_i = {s, 4'h5};
      @(negedge clk);
      eoc_i = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic read_chk(input string tag, input logic [AW-1:0] idx, input logic [11:0] exp);
      @(negedge clk);
      rd_en_i   = 1'b1;
      rd_addr_i = idx;
      @(negedge clk);
      rd_en_i = 1'b0;
      check({tag, "_valid"}, 16'(rd_valid_o), 16'd1);
      check(tag, 16'(rd_data_o), 16'(exp));
   endtask

   initial begin
      logic [11:0] s;

      repeat (2) @(negedge clk);
      check("rst_state", 16'(state_o), 16'd0);
      check("rst_done", 16'(done_o), 16'd0);
      check("rst_rd_valid", 16'(rd_valid_o), 16'd0);
      check("rst_rd_data", 16'(rd_data_o), 16'd0);
      check("rst_trig_addr", 16'(trig_addr_o), 16'd0);
      rstn = 1'b1;

      // rising ramp, pretrig 4, level 0x800
      arm(4'd4, 12'h800, 1'b0);
      check("t1_fill", 16'(state_o), 16'd1);
      @(negedge clk);
      rd_en_i = 1'b1;
      @(negedge clk);
      rd_en_i = 1'b0;
      check("t1_rd_not_done", 16'(rd_valid_o), 16'd0);
      for (int k = 0; k < 20; k++) begin
         s = 12'(k * 256);
         send(s);
         if (k == 3) check("t1_armed", 16'(state_o), 16'd2);
         if (k == 7) check("t1_no_trig_0x700", 16'(state_o), 16'd2);
         if (k == 8) begin
            check("t1_post", 16'(state_o), 16'd3);
            check("t1_trig_addr", 16'(trig_addr_o), 16'd8);
         end
         if (k == 18) check("t1_not_done_yet", 16'(done_o), 16'd0);
      end
      check("t1_done", 16'(done_o), 16'd1);
      check("t1_state_done", 16'(state_o), 16'd4);
      for (int i = 0; i < 16; i++) begin
         read_chk($sformatf("t1_rd%0d", i), AW'(i), 12'((4 + i) * 256));
      end
      @(negedge clk);
      check("t1_valid_drop", 16'(rd_valid_o), 16'd0);
      check("t1_data_hold", 16'(rd_data_o), 16'h300);

      // falling edge, pretrig 2, level 0x400, then abort+arm in POST
      arm(4'd2, 12'h400, 1'b1);
      check("t2_fill", 16'(state_o), 16'd1);
      check("t2_done_fall", 16'(done_o), 16'd0);
      send(12'h600);
      send(12'h500);
      check("t2_armed", 16'(state_o), 16'd2);
      send(12'h400);
      check("t2_post", 16'(state_o), 16'd3);
      check("t2_trig_addr", 16'(trig_addr_o), 16'd6);
      @(negedge clk);
      abort_i   = 1'b1;
      arm_i     = 1'b1;
      pretrig_i = 4'd0;
      @(negedge clk);
      abort_i = 1'b0;
      arm_i   = 1'b0;
      check("t2_abort_idle", 16'(state_o), 16'd0);
      check("t2_abort_done", 16'(done_o), 16'd0);
      send(12'h123);
      check("t2_idle_eoc", 16'(state_o), 16'd0);

      // pretrig 0: direct to ARMED, first sample ignored, arm in ARMED ignored
      arm(4'd0, 12'h800, 1'b0);
      check("t3_direct_armed", 16'(state_o), 16'd2);
      for (int k = 0; k < 6; k++) send(12'h900);
      check("t3_no_trig_0x900", 16'(state_o), 16'd2);
      arm(4'd5, 12'h100, 1'b1);
      check("t3_arm_ignored", 16'(state_o), 16'd2);
      send(12'h700);
      check("t3_still_armed", 16'(state_o), 16'd2);
      send(12'h800);
      check("t3_post", 16'(state_o), 16'd3);
      check("t3_trig_addr", 16'(trig_addr_o), 16'd14);
      for (int j = 1; j < 16; j++) begin
         s = 12'(12'h800 + j * 16);
         send(s);
         if (j == 14) check("t3_post_14", 16'(state_o), 16'd3);
      end
      check("t3_done", 16'(done_o), 16'd1);
      for (int i = 0; i < 16; i++) begin
         read_chk($sformatf("t3_rd%0d", i), AW'(i), 12'(12'h800 + i * 16));
      end

      // pre-trigger history across the address wrap
      arm(4'd4, 12'h800, 1'b0);
      for (int k = 0; k < 20; k++) begin
         s = 12'(12'h100 + k);
         send(s);
      end
      check("t4_armed", 16'(state_o), 16'd2);
      send(12'h900);
      check("t4_post", 16'(state_o), 16'd3);
      check("t4_trig_addr", 16'(trig_addr_o), 16'd2);
      for (int j = 0; j < 11; j++) begin
         s = 12'(12'hA00 + j);
         send(s);
      end
      check("t4_done", 16'(done_o), 16'd1);
      for (int i = 0; i < 4; i++) begin
         read_chk($sformatf("t4_rd%0d", i), AW'(i), 12'(12'h110 + i));
      end
      read_chk("t4_rd4", 4'd4, 12'h900);

      // async reset in the middle of POST
      arm(4'd1, 12'h800, 1'b0);
      send(12'h100);
      check("t5_armed", 16'(state_o), 16'd2);
      send(12'h900);
      check("t5_post", 16'(state_o), 16'd3);
      check("t5_trig_addr", 16'(trig_addr_o), 16'd15);
      @(negedge clk);
      rd_en_i = 1'b1;
      @(negedge clk);
      rd_en_i = 1'b0;
      check("t5_rd_in_post", 16'(rd_valid_o), 16'd0);
      check("t5_rd_hold", 16'(rd_data_o), 16'h900);
      @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      check("t5_rst_state", 16'(state_o), 16'd0);
      check("t5_rst_done", 16'(done_o), 16'd0);
      check("t5_rst_trig_addr", 16'(trig_addr_o), 16'd0);
      check("t5_rst_rd_valid", 16'(rd_valid_o), 16'd0);
      check("t5_rst_rd_data", 16'(rd_data_o), 16'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/scope_trigger_capture.md
Name: scope_trigger_capture

Overview:
- Sits directly downstream of the XADC AXI reader master.
- Consumes its 16-bit conversion word and end-of-conversion strobe.
- Runs oscilloscope edge triggering against a programmable level and stores pre- and post-trigger samples in a circular buffer.
- Exposes a trigger-aligned read port for the PS/display side.

Parameters:
- ADDR_W, 10, buffer address width; DEPTH = 2**ADDR_W samples.
- SAMPLE_W, 12, significant ADC bits, taken from val[15:4].

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rstn  in  1  asynchronous active-low reset.
- val_i  in  16  XADC conversion word from the upstream AXI reader; the sample is val_i[15:4].
- eoc_i  in  1  one-cycle strobe; val_i is valid in that cycle.
- arm_i  in  1  pulse; starts a capture.
- abort_i  in  1  pulse; cancels a capture and returns to IDLE.
- trig_level_i  in  12  trigger threshold.
- trig_edge_i  in  1  0 = rising, 1 = falling.
- pretrig_i  in  ADDR_W  number of samples kept before the trigger.
- rd_en_i  in  1  read request.
- rd_addr_i  in  ADDR_W  logical index; 0 = oldest sample, pretrig = trigger sample.
- rd_data_o  out  12  read data.
- rd_valid_o  out  1  rd_data_o valid.
- done_o  out  1  capture complete.
- state_o  out  3  FSM state, for debug.
- trig_addr_o  out  ADDR_W  physical address of the trigger sample.

Behaviour:
- Reset values: state IDLE, wr_ptr 0, counters 0, rd_data_o 0, rd_valid_o 0, done_o 0, trig_addr_o 0, prev_valid 0.
- State encoding: IDLE=0, FILL=1, ARMED=2, POST=3, DONE=4.
- IDLE/DONE + arm_i:
  - Latch level, edge and pretrig. Pretrig is clamped to DEPTH-1.
  - Clear prev_valid and the sample counter. Keep wr_ptr. done_o falls.
  - Go to FILL, or straight to ARMED if pretrig = 0.
- arm_i in FILL, ARMED or POST is ignored.
- abort_i in any state returns to IDLE next cycle and clears done_o. If abort_i and arm_i arrive together, abort wins.
- Every eoc_i in FILL, ARMED or POST:
  - Write s = val_i[15:4] at wr_ptr, then wr_ptr += 1 modulo DEPTH (wraps).
  - prev <= s; prev_valid <= 1.
- eoc_i in IDLE or DONE writes nothing.
- FILL: count the samples written. When the count reaches pretrig (on the writing cycle), go to ARMED.
- ARMED trigger condition, evaluated on an eoc_i cycle with prev_valid = 1:
  - Rising: prev < level and s >= level.
  - Falling: prev > level and s <= level.
  - Comparisons are unsigned 12-bit.
- On trigger:
  - The triggering sample is written.
  - trig_addr_o <= its address.
  - The post counter is loaded with DEPTH - pretrig - 1.
  - Go to POST, or to DONE if the counter value is 0.
- The first sample after arming never triggers (prev_valid = 0).
- Samples written in ARMED before the trigger overwrite the oldest pre-trigger data. The buffer always holds the latest pretrig samples preceding the trigger.
- POST: decrement the counter on each eoc_i write. The write that takes it to 0 moves the FSM to DONE and asserts done_o the next cycle.
- Total stored per capture = DEPTH samples: pretrig before the trigger, the trigger sample, then DEPTH - pretrig - 1 after it.
- Read port:
  - phys = trig_addr - pretrig + rd_addr_i, modulo DEPTH.
  - Latency 1 cycle: rd_valid_o = registered (rd_en_i and state == DONE).
  - rd_data_o holds its value when no read is issued.
  - Reads in other states give rd_valid_o = 0.
- Reset mid-capture: immediately IDLE; buffer contents are undefined.

Decomposition:
- Package scope_pkg holds:
  - state enum/localparams (IDLE..DONE),
  - SAMPLE_MSB = 15, SAMPLE_LSB = 4,
  - edge encoding constants EDGE_RISE = 0, EDGE_FALL = 1.
- Sub-module scope_sample_ram: simple dual-port RAM, DEPTH x 12, synchronous write, synchronous registered read. Infers BRAM, no reset on the array.

Test Plan:
- ADDR_W=4, arm, pretrig=4, level=0x800, rising; feed ramp samples 0x000,0x100,...,0xF00 (val_i = s<<4) at one eoc per 4 clocks -> trigger on 0x800. Reads 0..15 return 0x400,0x500,0x600,0x700,0x800 then continuing ramp values. done_o after the 11th post sample.
- Falling edge, level 0x400, samples 0x600,0x500,0x400 -> trigger at 0x400; trig_addr_o equals that sample's write address.
- Level 0x800, first post-arm sample 0x900 then 0x900s -> no trigger, stays ARMED (state_o=2). Then 0x700,0x800 -> trigger on 0x800.
- pretrig=0 -> FSM goes IDLE->ARMED directly; read index 0 returns the trigger sample; exactly 16 samples are captured.
- Pretrig wrap: pretrig=4, 20 sub-level samples before the trigger, wr_ptr starting at 14 -> reads 0..3 return the 4 samples immediately preceding the trigger, across the address wrap.
- abort_i with arm_i in POST -> IDLE, done_o=0, eoc_i ignored. arm_i during ARMED -> no effect. Async rstn low mid-POST -> all outputs at reset values within the same cycle.
